ram_fill_check: RTL and testbench
=================================

# ram_fill_check

Self-checking writer/reader for a 32x8 simple-dual-port block RAM. It is the write-side counterpart to the board's sequential ROM readout. On a start pulse it fills every RAM location with a deterministic pattern through port A, reads every location back through port B, and compares each word against the expected value. It then reports pass/fail and an error count. It sits between the top-level test wrapper and the `ram_ip` core, which has a write port A, a read port B and 1-cycle read latency.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width; depth = 2^ADDR_W
- `DATA_W`, 8, RAM data width
- `SEED`, 8'h00, pattern offset; expected data = (SEED + addr) mod 2^DATA_W

Ports:
- `sysclk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle request; honoured only in IDLE or DONE
- `busy`  out  1  high from the first WRITE cycle through DRAIN
- `done`  out  1  high while in DONE
- `pass`  out  1  valid while `done`=1; 1 iff `err_cnt`==0
- `err_cnt`  out  ADDR_W+1  count of mismatching read-back words
- `wr_en`  out  1  RAM port A write enable
- `wr_addr`  out  ADDR_W  RAM port A address
- `wr_data`  out  DATA_W  RAM port A data
- `rd_addr`  out  ADDR_W  RAM port B address
- `rd_data`  in  DATA_W  RAM port B data, valid one cycle after `rd_addr`

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE -> WRITE when `start`=1. On this transition `err_cnt` is cleared and the address counter is set to 0.
- WRITE: `wr_en`=1, `wr_addr`=counter, `wr_data`=(SEED+counter) truncated to DATA_W. The counter increments each cycle. After address 2^ADDR_W-1 the state goes to READ and the counter wraps to 0.
- READ: `rd_addr`=counter, and the counter increments each cycle. A 1-cycle delayed valid flag and a delayed copy of the expected data are registered alongside. After the last address the state goes to DRAIN.
- Compare: whenever the delayed valid flag is 1 and `rd_data` differs from the delayed expected value, `err_cnt` increments. The maximum count is 2^ADDR_W, which fits in the counter without saturation logic.
- DRAIN: one cycle in which the final read word is compared. The state then goes to DONE.
- DONE: `done`=1 and `pass`=(`err_cnt`==0). Both hold until the next `start`, which behaves like a start from IDLE.
- `start` is ignored in WRITE, READ and DRAIN.
- `wr_en`=0 outside WRITE.
- `wr_addr`, `wr_data` and `rd_addr` are 0 when their port is idle.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `wr_en`=0; `err_cnt`, `wr_addr`, `wr_data`, `rd_addr`=0; delayed valid flag = 0.
- `rst_n` low at any point aborts the sequence immediately and returns all outputs to their reset values. RAM contents are left as partially written.
- Let edge 0 be the edge where `start` is sampled.
- WRITE occupies cycles 1..32 (write to address k at cycle k+1).
- READ occupies cycles 33..64.
- DRAIN is cycle 65.
- `done` and `pass` rise at cycle 66.
- `busy` is high for cycles 1..65.
- All outputs are registered. No combinational path from `start` or `rd_data` to any output.

## Configuration
- `RAM_FILL_ILA_EN` defined: instantiate `chipscope_icon` and `chipscope_ila` clocked by `sysclk`, with this TRIG0 mapping:
  - [4:0] = `wr_addr`
  - [12:5] = `wr_data`
  - [13] = `wr_en`
  - [18:14] = `rd_addr`
  - [26:19] = `rd_data`
  - [32:27] = `err_cnt`
  - [35:33] = state
  - remaining bits tied to 0
- Not defined: no debug cores are instantiated. Functional behaviour is identical with or without the macro.

## Structure
- Shared include `ram_fill_defs.vh` holds:
  - state encodings (3-bit localparams)
  - the default depth/width constants
  - the TRIG0 bit-slice constants
- Sub-module `ram_fill_cmp` holds:
  - the delayed valid/expected registers
  - the comparator
  - `err_cnt`, with a clear input
- The parent holds the FSM, the address counter and the pattern generator.

## Test plan
- Reset, then pulse `start` with an ideal 1-cycle-latency RAM model and SEED=0:
  - writes occur as addr k / data k for k=0..31
  - `done`=1 at cycle 66, `pass`=1, `err_cnt`=0
- RAM model forces bit 0 of address 5's read data to be inverted -> `err_cnt`=1, `pass`=0 at cycle 66.
- Pulse `start` again at cycle 20 (during WRITE) -> ignored; the sequence still finishes at cycle 66 with `err_cnt`=0.
- Drive `rst_n` low during WRITE at address 10:
  - all outputs are 0 on the next sample
  - a new `start` restarts with `wr_addr`=0 and finishes with `pass`=1
- SEED=8'hF0 -> address 16 is written with 8'h00 and address 31 with 8'h0F; `pass`=1.
- From DONE with `err_cnt`=3, pulse `start`:
  - next cycle `done`=0, `pass`=0, `err_cnt`=0, `busy`=1
  - a clean RAM model then yields `pass`=1

Source files
------------

// File: rtl/ram_fill_check_pkg.sv
// ram_fill_check_pkg: shared constants for the RAM fill/check block.
// Holds the 3-bit state encodings, default geometry and the debug trigger
// bus bit map used when RAM_FILL_ILA_EN is defined.
package ram_fill_check_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   // Trigger bus layout assumes the default 5-bit address / 8-bit data geometry.
   localparam int TRIG_W          = 36;
   localparam int TRIG_WR_ADDR_LO = 0;
   localparam int TRIG_WR_ADDR_HI = 4;
   localparam int TRIG_WR_DATA_LO = 5;
   localparam int TRIG_WR_DATA_HI = 12;
   localparam int TRIG_WR_EN      = 13;
   localparam int TRIG_RD_ADDR_LO = 14;
   localparam int TRIG_RD_ADDR_HI = 18;
   localparam int TRIG_RD_DATA_LO = 19;
   localparam int TRIG_RD_DATA_HI = 26;
   localparam int TRIG_ERR_LO     = 27;
   localparam int TRIG_ERR_HI     = 32;
   localparam int TRIG_STATE_LO   = 33;
   localparam int TRIG_STATE_HI   = 35;

endpackage

// File: rtl/ram_fill_cmp.sv
// ram_fill_cmp: read-back comparator. Registers a 1-cycle delayed valid flag
// and expected word alongside each read request so they line up with the
// RAM's 1-cycle read latency, and counts mismatching words.
module ram_fill_cmp
   import ram_fill_check_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              rd_req,
   input  logic [DATA_W-1:0] rd_exp,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   err_cnt_nxt,
   output logic [ADDR_W:0]   err_cnt
);

   logic              vld_q, vld_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [ADDR_W:0]   err_cnt_q, err_cnt_d;

   // Delay the request by one cycle and compare against the returned word.
   always_comb begin
      vld_d     = clr ? 1'b0 : rd_req;
      exp_d     = rd_req ? rd_exp : '0;
      err_cnt_d = err_cnt_q;
      if (clr) begin
         err_cnt_d = '0;
      end else if (vld_q && (rd_data != exp_q)) begin
         err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
      end
   end

   // Compare pipeline and error counter registers.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= 1'b0;
         exp_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         vld_q     <= vld_d;
         exp_q     <= exp_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_nxt = err_cnt_d;
   assign err_cnt     = err_cnt_q;

endmodule

// File: rtl/ram_fill_check.sv
// ram_fill_check: fills a simple-dual-port RAM with (SEED + addr), reads it
// back and reports pass/fail plus a mismatch count.
// Optional debug cores: define RAM_FILL_ILA_EN to attach chipscope_icon /
// chipscope_ila on sysclk; behaviour is unchanged either way.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start after reset
// WRITE    | writing pattern to every address via port A
// READ     | issuing reads for every address via port B
// DRAIN    | last read word returns and is compared
// DONE     | result valid; start launches a new run
module ram_fill_check
   import ram_fill_check_pkg::*;
#(
   parameter int                 ADDR_W = ADDR_W_DEF,
   parameter int                 DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0]  SEED   = '0
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              clr;
   logic              rd_req;
   logic [DATA_W-1:0] rd_exp;
   logic [ADDR_W:0]   err_cnt_nxt;

   // Next state and address counter; counter wraps to 0 after the last address.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_WRITE;
               cnt_d   = '0;
               clr     = 1'b1;
            end
         end
         ST_WRITE: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) state_d = ST_READ;
         end
         ST_READ: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from next state so the registered copies line up
   // with the state they describe.
   always_comb begin
      wr_en_d   = (state_d == ST_WRITE);
      wr_addr_d = wr_en_d ? cnt_d : '0;
      wr_data_d = wr_en_d ? (SEED + DATA_W'(cnt_d)) : '0;
      rd_addr_d = (state_d == ST_READ) ? cnt_d : '0;
      busy_d    = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
      done_d    = (state_d == ST_DONE);
      pass_d    = done_d && (err_cnt_nxt == '0);
   end

   // The word requested this cycle is what the RAM returns next cycle.
   assign rd_req = (state_q == ST_READ);
   assign rd_exp = SEED + DATA_W'(cnt_q);

   // FSM, counter and registered outputs.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   ram_fill_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .clr         (clr),
      .rd_req      (rd_req),
      .rd_exp      (rd_exp),
      .rd_data     (rd_data),
      .err_cnt_nxt (err_cnt_nxt),
      .err_cnt     (err_cnt)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign rd_addr = rd_addr_q;

`ifdef RAM_FILL_ILA_EN
   logic [35:0]       ila_control;
   logic [TRIG_W-1:0] ila_trig0;

   // Pack the debug trigger bus; unused bits stay 0.
   always_comb begin
      ila_trig0 = '0;
      ila_trig0[TRIG_WR_ADDR_HI:TRIG_WR_ADDR_LO] = wr_addr_q;
      ila_trig0[TRIG_WR_DATA_HI:TRIG_WR_DATA_LO] = wr_data_q;
      ila_trig0[TRIG_WR_EN]                      = wr_en_q;
      ila_trig0[TRIG_RD_ADDR_HI:TRIG_RD_ADDR_LO] = rd_addr_q;
      ila_trig0[TRIG_RD_DATA_HI:TRIG_RD_DATA_LO] = rd_data;
      ila_trig0[TRIG_ERR_HI:TRIG_ERR_LO]         = err_cnt;
      ila_trig0[TRIG_STATE_HI:TRIG_STATE_LO]     = state_q;
   end

   chipscope_icon u_icon (
      .CONTROL0 (ila_control)
   );

   chipscope_ila u_ila (
      .CONTROL (ila_control),
      .CLK     (sysclk),
      .TRIG0   (ila_trig0)
   );
`endif

endmodule

// File: tb/tb_ram_fill_check.sv
// tb_ram_fill_check: drives two instances (SEED 0 and SEED 8'hF0), each with
// its own 1-cycle-latency RAM model. Writes are checked by a scoreboard,
// scenarios come from a vector table plus hand-written corner sequences.
module tb_ram_fill_check;

   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   logic       rst_n;
   logic       start0, start1;
   logic       busy0, done0, pass0, wr_en0;
   logic       busy1, done1, pass1, wr_en1;
   logic [5:0] err_cnt0, err_cnt1;
   logic [4:0] wr_addr0, rd_addr0, wr_addr1, rd_addr1;
   logic [7:0] wr_data0, wr_data1;
   logic [7:0] rd_data0 = '0;
   logic [7:0] rd_data1 = '0;

   logic [7:0] mem0 [32];
   logic [7:0] mem1 [32];
   logic [7:0] flip [32];

   ram_fill_check #(.ADDR_W(5), .DATA_W(8), .SEED(8'h00)) dut0 (
      .sysclk(sysclk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
      .pass(pass0), .err_cnt(err_cnt0), .wr_en(wr_en0), .wr_addr(wr_addr0),
      .wr_data(wr_data0), .rd_addr(rd_addr0), .rd_data(rd_data0)
   );

   ram_fill_check #(.ADDR_W(5), .DATA_W(8), .SEED(8'hF0)) dut1 (
      .sysclk(sysclk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err_cnt1), .wr_en(wr_en1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .rd_addr(rd_addr1), .rd_data(rd_data1)
   );

   // RAM models: write port A, registered read port B with optional bit flips.
   always @(posedge sysclk) begin
      if (wr_en0) mem0[wr_addr0] <= wr_data0;
      if (wr_en1) mem1[wr_addr1] <= wr_data1;
      rd_data0 <= mem0[rd_addr0] ^ flip[rd_addr0];
      rd_data1 <= mem1[rd_addr1];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct packed {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t wq0[$];
   wr_t wq1[$];
   wr_t e0, e1;

   // Scoreboard: every write the DUT issues must match the next expected one.
   always @(negedge sysclk) begin
      if (rst_n && wr_en0) begin
         if (wq0.size() == 0) check("wr0_unexpected", 32'd1, 32'd0);
         else begin
            e0 = wq0.pop_front();
            check("wr0_addr", 32'(wr_addr0), 32'(e0.a));
            check("wr0_data", 32'(wr_data0), 32'(e0.d));
         end
      end
      if (rst_n && wr_en1) begin
         if (wq1.size() == 0) check("wr1_unexpected", 32'd1, 32'd0);
         else begin
            e1 = wq1.pop_front();
            check("wr1_addr", 32'(wr_addr1), 32'(e1.a));
            check("wr1_data", 32'(wr_data1), 32'(e1.d));
         end
      end
   end

   // Queue the expected writes, then pulse start; returns just after edge 0.
   task automatic pulse_start(input int sel, input logic [7:0] seed);
      wr_t w;
      for (int k = 0; k < 32; k++) begin
         w.a = 5'(k);
         w.d = seed + 8'(k);
         if (sel == 0) wq0.push_back(w); else wq1.push_back(w);
      end
      @(posedge sysclk); #1;
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge sysclk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Wait (bounded) for done; done_edge is the edge after which done is seen.
   task automatic wait_done(input int sel, input int restart_at, output int done_edge);
      done_edge = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge sysclk); #1;
         if (sel == 0) start0 = (i == restart_at - 1);
         else          start1 = (i == restart_at - 1);
         if ((sel == 0) ? done0 : done1) begin
            done_edge = i;
            break;
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [31:0] bad_addrs;
      logic [7:0]  bad_bits;
      int          restart_at;
      int          exp_err;
      bit          exp_pass;
   } vec_t;

   vec_t vecs[5];

   task automatic set_flips(input logic [31:0] addrs, input logic [7:0] bits);
      for (int a = 0; a < 32; a++) flip[a] = addrs[a] ? bits : 8'h00;
   endtask

   initial begin
      int de;
      vecs[0] = '{"clean",      32'h0000_0000, 8'h00, -10, 0,  1'b1};
      vecs[1] = '{"addr5_bit0", 32'h0000_0020, 8'h01, -10, 1,  1'b0};
      vecs[2] = '{"restart_20", 32'h0000_0000, 8'h00, 20,  0,  1'b1};
      vecs[3] = '{"edges_x3",   32'h8002_0001, 8'h80, -10, 3,  1'b0};
      vecs[4] = '{"all_bad",    32'hFFFF_FFFF, 8'hFF, -10, 32, 1'b0};

      set_flips('0, 8'h00);
      for (int a = 0; a < 32; a++) begin
         mem0[a] = 8'hA5;
         mem1[a] = 8'hA5;
      end
      start0 = 1'b0;
      start1 = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(posedge sysclk);
      #1;
      check("reset_outs0", {busy0, done0, pass0, wr_en0, err_cnt0, wr_addr0, wr_data0, rd_addr0}, '0);
      check("reset_outs1", {busy1, done1, pass1, wr_en1, err_cnt1, wr_addr1, wr_data1, rd_addr1}, '0);
      rst_n = 1'b1;

      foreach (vecs[v]) begin
         set_flips(vecs[v].bad_addrs, vecs[v].bad_bits);
         pulse_start(0, 8'h00);
         check({vecs[v].name, "_busy_c1"}, 32'(busy0), 32'd1);
         wait_done(0, vecs[v].restart_at, de);
         check({vecs[v].name, "_done_edge"}, de, 65);
         check({vecs[v].name, "_err_cnt"}, 32'(err_cnt0), vecs[v].exp_err);
         check({vecs[v].name, "_pass"}, 32'(pass0), 32'(vecs[v].exp_pass));
         check({vecs[v].name, "_busy_done"}, 32'(busy0), 32'd0);
         check({vecs[v].name, "_wq_empty"}, wq0.size(), 0);
      end

      // Reset in the middle of WRITE at address 10, then a clean restart.
      set_flips('0, 8'h00);
      pulse_start(0, 8'h00);
      repeat (10) begin
         @(posedge sysclk); #1;
      end
      check("abort_wr_addr", 32'(wr_addr0), 32'd10);
      rst_n = 1'b0;
      #1;
      check("abort_outs", {busy0, done0, pass0, wr_en0, err_cnt0, wr_addr0, wr_data0, rd_addr0}, '0);
      wq0.delete();
      @(posedge sysclk); #1;
      rst_n = 1'b1;
      pulse_start(0, 8'h00);
      check("restart_wr_addr", 32'(wr_addr0), 32'd0);
      wait_done(0, -10, de);
      check("restart_done_edge", de, 65);
      check("restart_pass", 32'(pass0), 32'd1);

      // Non-zero seed: pattern wraps through zero at address 16.
      pulse_start(1, 8'hF0);
      wait_done(1, -10, de);
      check("seed_done_edge", de, 65);
      check("seed_mem16", 32'(mem1[16]), 32'h00);
      check("seed_mem31", 32'(mem1[31]), 32'h0F);
      check("seed_pass", 32'(pass1), 32'd1);
      check("seed_wq_empty", wq1.size(), 0);

      // Start from DONE with a nonzero error count.
      set_flips(32'h0000_0444, 8'h10);
      pulse_start(0, 8'h00);
      wait_done(0, -10, de);
      check("redo_err3", 32'(err_cnt0), 32'd3);
      set_flips('0, 8'h00);
      pulse_start(0, 8'h00);
      check("redo_c1", {done0, pass0, err_cnt0, busy0}, {1'b0, 1'b0, 6'd0, 1'b1});
      wait_done(0, -10, de);
      check("redo_done_edge", de, 65);
      check("redo_pass", 32'(pass0), 32'd1);
      check("redo_err0", 32'(err_cnt0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
